pixel_stream_arbiter: RTL and testbench
=======================================

PIXEL_STREAM_ARBITER -- requirements
Module: pixel_stream_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, pixel data width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports fifo0_rdreq / fifo1_rdreq, output, 1 each, read request to source FIFO 0 / 1.
REQ-007 SHALL have ports fifo0_data / fifo1_data, input, DWIDTH each, FIFO read data, valid the cycle after rdreq.
REQ-008 SHALL have ports fifo0_empty / fifo1_empty, input, 1 each, FIFO empty flags.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DWIDTH), the sink handshake; transfer when both valid and ready are high.
REQ-010 SHALL have outputs out_sof, out_eol and out_eof, 1 each, qualified by out_valid: first pixel of frame, last pixel of line, last pixel of frame.
REQ-011 SHALL have output out_src, 1, source index of the current out_data.

Function
REQ-012 SHALL use a state machine with states IDLE, STREAM and DRAIN.
REQ-013 IDLE: SHALL grant the source with priority whose empty is low, else the other source if its empty is low, else stay in IDLE; a grant moves to STREAM.
REQ-014 Priority SHALL start at source 0 and toggle only after a frame's out_eof transfer (round-robin per frame).
REQ-015 STREAM: SHALL assert the granted rdreq only when its empty is low and buffer occupancy plus in-flight reads is less than 2; the ungranted rdreq SHALL stay low.
REQ-016 Data SHALL be captured into a 2-entry buffer one cycle after rdreq; out_valid SHALL be high whenever the buffer is non-empty.
REQ-017 Sustained throughput SHALL be 1 pixel/cycle with out_ready high and the source non-empty; first-pixel latency from grant SHALL be 2 cycles.
REQ-018 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) SHALL advance on each output transfer, wrapping column to 0 and incrementing row at end of line.
REQ-019 out_sof SHALL be high at col=0,row=0; out_eol at col=IMG_WIDTH-1; out_eof at col=IMG_WIDTH-1,row=IMG_HEIGHT-1.
REQ-020 After IMG_WIDTH*IMG_HEIGHT reads have been issued, SHALL enter DRAIN with both rdreq low, and return to IDLE on the out_eof transfer.
REQ-021 A source going empty mid-frame SHALL stall the frame and SHALL NOT switch grant; out_valid drops when the buffer empties.
REQ-022 out_ready low SHALL hold out_data and flags stable and stop rdreq once the buffer is committed full; no pixel is lost or duplicated.
REQ-023 Both sources non-empty in IDLE simultaneously SHALL resolve by the priority bit only.

Reset
REQ-024 On reset: state IDLE, priority 0, counters 0, buffer empty, all rdreq, out_valid and flags 0, out_data 0, out_src 0.
REQ-025 Reset mid-frame SHALL abandon the frame; in-flight FIFO data arriving the next cycle SHALL be discarded.

Configuration
REQ-026 Macro PIXEL_ARB_FRAME_CNT_EN defined: SHALL add outputs frame_cnt0 and frame_cnt1, 16 bits each, incremented on each out_eof transfer of that source, wrapping at 65535, cleared by reset.
REQ-027 Without PIXEL_ARB_FRAME_CNT_EN: those ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-028 Package pixel_arb_pkg SHALL hold the state enum and the counter-width helper functions (clog2 of IMG_WIDTH and IMG_HEIGHT).
REQ-029 The 2-entry buffer SHALL be a sub-module pixel_skid_buffer (push, data, pop, count, head).

Verification
REQ-030 IMG_WIDTH=4, IMG_HEIGHT=2, fifo0 holding 8 pixels 0x10..0x17, out_ready=1 -> 8 consecutive transfers; sof on 0x10, eol on 0x13 and 0x17, eof on 0x17; out_src=0.
REQ-031 Both FIFOs non-empty from reset -> frame from src 0, then src 1, then src 0; no interleaving within a frame.
REQ-032 Toggle out_ready 1,0,0,1 repeatedly during a frame -> output sequence is exact with no loss or duplicates, and rdreq is never issued when the buffer is committed full.
REQ-033 fifo0 empties after 3 pixels while fifo1 is non-empty -> grant stays on 0; the frame resumes when fifo0 refills.
REQ-034 Reset asserted mid-frame with a read in flight -> all outputs 0 next cycle; the stale pixel is never emitted; the next frame starts with sof from src 0.
REQ-035 With PIXEL_ARB_FRAME_CNT_EN, 3 frames alternating sources -> frame_cnt0=2, frame_cnt1=1.

Source files
------------

// File: rtl/pixel_arb_pkg.sv
// Shared types and counter-width helpers for the pixel stream arbiter.
package pixel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  function automatic int col_width(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int row_width(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry pixel buffer: push lands the cycle after a FIFO read, head is the oldest entry.
// Caller must never push into a committed-full buffer nor pop an empty one.
module pixel_skid_buffer #(
  parameter int DWIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] entry0;
  logic [DWIDTH-1:0] entry1;

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= data;
          else               entry1 <= data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new pixel goes behind whatever remains.
          if (count == 2'd1) begin
            entry0 <= data;
          end else begin
            entry0 <= entry1;
            entry1 <= data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/pixel_stream_arbiter.sv
// Frame-granular round-robin arbiter merging two pixel FIFOs into one stream with sof/eol/eof.
// First pixel 2 cycles after grant, 1 pixel/cycle sustained; optional per-source frame counters under PIXEL_ARB_FRAME_CNT_EN.
module pixel_stream_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clock,
  input  logic              reset,
  output logic              fifo0_rdreq,
  input  logic [DWIDTH-1:0] fifo0_data,
  input  logic              fifo0_empty,
  output logic              fifo1_rdreq,
  input  logic [DWIDTH-1:0] fifo1_data,
  input  logic              fifo1_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              out_src
`ifdef PIXEL_ARB_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt0,
  output logic [15:0]       frame_cnt1
`endif
);

  localparam int COL_W = col_width(IMG_WIDTH);
  localparam int ROW_W = row_width(IMG_HEIGHT);
  localparam int RD_W  = COL_W + ROW_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [RD_W-1:0]  LAST_RD  = RD_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              prio;
  logic              grant;
  logic [RD_W-1:0]   rd_cnt;
  logic              inflight;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        buf_count;
  logic [DWIDTH-1:0] buf_head;
  logic              sel_empty;
  logic [DWIDTH-1:0] sel_data;
  logic              src_avail;
  logic              pick_src;
  logic              xfer;
  logic              eof_xfer;
  logic [2:0]        occ;
  logic              rd_ok;

  assign sel_empty = grant ? fifo1_empty : fifo0_empty;
  assign sel_data  = grant ? fifo1_data  : fifo0_data;
  assign src_avail = ~fifo0_empty | ~fifo1_empty;
  assign pick_src  = prio ? ~fifo1_empty : fifo0_empty;

  assign out_valid = (buf_count != 2'd0);
  assign xfer      = out_valid & out_ready;
  assign eof_xfer  = xfer & out_eof;

  // Committed occupancy credits a pop happening this cycle so a full pipe still streams 1/cycle.
  assign occ   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, xfer};
  assign rd_ok = (state == STREAM) && !reset && !sel_empty && (occ < 3'd2);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (src_avail) state_nxt = STREAM;
      STREAM:  if (rd_ok && rd_cnt == LAST_RD) state_nxt = DRAIN;
      DRAIN:   if (eof_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo0_rdreq = 1'b0;
    fifo1_rdreq = 1'b0;
    if (rd_ok) begin
      fifo0_rdreq = ~grant;
      fifo1_rdreq = grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio     <= 1'b0;
      grant    <= 1'b0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
      col      <= '0;
      row      <= '0;
    end else begin
      inflight <= rd_ok;
      if (state == IDLE && src_avail) begin
        grant  <= pick_src;
        rd_cnt <= '0;
      end else if (rd_ok) begin
        rd_cnt <= rd_cnt + RD_W'(1);
      end
      if (xfer) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (eof_xfer) prio <= ~prio;
    end
  end

  // Grant only changes in IDLE, when the buffer is already empty, so it tags every buffered pixel.
  pixel_skid_buffer #(.DWIDTH(DWIDTH)) u_buf (
    .clock (clock),
    .reset (reset),
    .push  (inflight),
    .data  (sel_data),
    .pop   (xfer),
    .count (buf_count),
    .head  (buf_head)
  );

  assign out_data = buf_head;
  assign out_src  = grant;
  assign out_sof  = out_valid && (col == '0) && (row == '0);
  assign out_eol  = out_valid && (col == LAST_COL);
  assign out_eof  = out_valid && (col == LAST_COL) && (row == LAST_ROW);

`ifdef PIXEL_ARB_FRAME_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt0 <= 16'd0;
      frame_cnt1 <= 16'd0;
    end else if (eof_xfer) begin
      if (grant) frame_cnt1 <= frame_cnt1 + 16'd1;
      else       frame_cnt0 <= frame_cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Directed bench for pixel_stream_arbiter at 4x2 frames with behavioural source FIFOs and an expected-pixel queue.
module tb_pixel_stream_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo0_rdreq, fifo1_rdreq;
  logic [7:0] fifo0_data = 8'h00;
  logic [7:0] fifo1_data = 8'h00;
  logic       fifo0_empty = 1'b1;
  logic       fifo1_empty = 1'b1;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sof, out_eol, out_eof, out_src;
`ifdef PIXEL_ARB_FRAME_CNT_EN
  logic [15:0] frame_cnt0, frame_cnt1;
`endif

  pixel_stream_arbiter #(.DWIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .fifo0_rdreq (fifo0_rdreq),
    .fifo0_data  (fifo0_data),
    .fifo0_empty (fifo0_empty),
    .fifo1_rdreq (fifo1_rdreq),
    .fifo1_data  (fifo1_data),
    .fifo1_empty (fifo1_empty),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .out_eof     (out_eof),
    .out_src     (out_src)
`ifdef PIXEL_ARB_FRAME_CNT_EN
    ,
    .frame_cnt0  (frame_cnt0),
    .frame_cnt1  (frame_cnt1)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          passed = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [11:0] exp_q[$];
  int          held = 0;
  int          xfers = 0;
  int          cyc = 0;
  int          first_xfer = 0;
  int          last_xfer = 0;
  int          rd1_cnt = 0;
  bit          hold_chk = 0;
  logic [11:0] hold_val = '0;
  bit          last_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic logic [11:0] cur();
    return {out_data, out_sof, out_eol, out_eof, out_src};
  endfunction

  // Expected pixel word for index idx within a 4x2 frame.
  function automatic logic [11:0] mk(input logic [7:0] d, input int idx, input logic src);
    logic sof, eol, eof;
    sof = (idx == 0);
    eol = (idx % 4 == 3);
    eof = (idx == 7);
    return {d, sof, eol, eof, src};
  endfunction

  task automatic update_empty();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
  endtask

  task automatic load(input bit src, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (src) q1.push_back(base + 8'(i));
      else     q0.push_back(base + 8'(i));
    end
    update_empty();
  endtask

  task automatic expect_frame(input logic [7:0] base, input int first_idx, input int n, input logic src);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(base + 8'(i), first_idx + i, src));
  endtask

  task automatic tick();
    logic rd0, rd1, xf;
    logic [11:0] e;
    @(negedge clock);
    rd0 = fifo0_rdreq;
    rd1 = fifo1_rdreq;
    xf  = out_valid && out_ready;
    if (rd0 || rd1) begin
      chk("single_rdreq", 32'(rd0 && rd1), 0);
      chk("rdreq_when_full", 32'((held - (xf ? 1 : 0)) < 2), 1);
    end
    if (hold_chk) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data_flags", 32'(cur()), 32'(hold_val));
    end
    hold_chk = out_valid && !out_ready;
    hold_val = cur();
    if (xf) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", 32'(cur()), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", 32'(cur()), 32'(e));
      end
      held--;
      xfers++;
      if (xfers == 1) first_xfer = cyc;
      last_xfer = cyc;
    end
    if (rd0 || rd1) held++;
    if (rd1) rd1_cnt++;
    last_rd = rd0 || rd1;
    @(posedge clock);
    #1;
    cyc++;
    if (rd0) begin
      if (q0.size() > 0) fifo0_data = q0.pop_front();
      else chk("fifo0_underflow", 32'(q0.size()), 1);
    end
    if (rd1) begin
      if (q1.size() > 0) fifo1_data = q1.pop_front();
      else chk("fifo1_underflow", 32'(q1.size()), 1);
    end
    update_empty();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    update_empty();
    hold_chk = 0;
    tick();
    tick();
    held = 0;
    xfers = 0;
    rd1_cnt = 0;
    hold_chk = 0;
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic run_drain(input int budget, input bit pattern);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (pattern) out_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    chk("drain_budget", 32'(exp_q.size()), 0);
    out_ready = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdreq0"}, 32'(fifo0_rdreq), 0);
    chk({tag, "_rdreq1"}, 32'(fifo1_rdreq), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data_flags_src"}, 32'(cur()), 0);
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    chk_all_zero("reset");
`ifdef PIXEL_ARB_FRAME_CNT_EN
    chk("reset_frame_cnt0", 32'(frame_cnt0), 0);
    chk("reset_frame_cnt1", 32'(frame_cnt1), 0);
`endif

    // Single frame from fifo0, latency and throughput
    load(0, 8'h10, 8);
    expect_frame(8'h10, 0, 8, 1'b0);
    tick();
    chk("lat_cycle1_valid", 32'(out_valid), 0);
    tick();
    chk("lat_cycle2_valid", 32'(out_valid), 0);
    tick();
    chk("lat_first_valid", 32'(out_valid), 1);
    chk("lat_first_pixel", 32'(cur()), 32'(mk(8'h10, 0, 1'b0)));
    run_drain(30, 0);
    chk("frame_xfers", 32'(xfers), 8);
    chk("frame_back_to_back", 32'(last_xfer - first_xfer), 7);
    tick();
    chk("after_frame_valid", 32'(out_valid), 0);

    // Both sources busy: frames alternate 0,1,0 with no interleave
    do_reset();
    load(0, 8'h20, 16);
    load(1, 8'hA0, 8);
    expect_frame(8'h20, 0, 8, 1'b0);
    expect_frame(8'hA0, 0, 8, 1'b1);
    expect_frame(8'h28, 0, 8, 1'b0);
    run_drain(100, 0);
`ifdef PIXEL_ARB_FRAME_CNT_EN
    tick();
    chk("frame_cnt0", 32'(frame_cnt0), 2);
    chk("frame_cnt1", 32'(frame_cnt1), 1);
`endif

    // Backpressure pattern 1,0,0,1
    do_reset();
    load(0, 8'h30, 8);
    expect_frame(8'h30, 0, 8, 1'b0);
    run_drain(80, 1);
    chk("bp_xfers", 32'(xfers), 8);

    // fifo0 runs dry mid-frame while fifo1 waits
    do_reset();
    load(0, 8'h40, 3);
    load(1, 8'hB0, 8);
    expect_frame(8'h40, 0, 8, 1'b0);
    expect_frame(8'hB0, 0, 8, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    chk("stall_xfers", 32'(xfers), 3);
    chk("stall_valid", 32'(out_valid), 0);
    chk("stall_no_rdreq1", 32'(rd1_cnt), 0);
    chk("stall_src", 32'(out_src), 0);
    load(0, 8'h43, 5);
    run_drain(80, 0);
    chk("stall_total_xfers", 32'(xfers), 16);

    // Reset mid-frame with a read in flight
    do_reset();
    load(0, 8'h50, 8);
    expect_frame(8'h50, 0, 8, 1'b0);
    n = 0;
    while (n < 30 && !(xfers >= 3 && last_rd)) begin
      tick();
      n++;
    end
    chk("midreset_read_in_flight", 32'(last_rd), 1);
    reset = 1'b1;
    out_ready = 1'b0;
    hold_chk = 0;
    tick();
    chk_all_zero("midreset");
    do_reset();
    load(0, 8'h60, 8);
    expect_frame(8'h60, 0, 8, 1'b0);
    run_drain(40, 0);
    chk("midreset_next_frame_xfers", 32'(xfers), 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
